// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // The MEM stage holds the younger result, so it wins over WB.
    function automatic logic [1:0] fwd_sel(input logic       mem_wr,
                                           input logic [4:0] mem_rd,
                                           input logic       wb_wr,
                                           input logic [4:0] wb_rd,
                                           input logic [4:0] rs);
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_wr && mem_rd != 5'd0 && mem_rd == rs)
            sel = FWD_MEM;
        else if (wb_wr && wb_rd != 5'd0 && wb_rd == rs)
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding selects for both ALU operands.
module forwarding_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_ex_rs1,
    input  logic [4:0] i_ex_rs2,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_reg_write,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_reg_write,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b
);

    assign o_fwd_a = fwd_sel(i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd, i_ex_rs1);
    assign o_fwd_b = fwd_sel(i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd, i_ex_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing: memory-wait freeze with timeout, redirect flush,
// load-use bubble, forwarding selects and stall/flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int            WC_W   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

    state_t            r_state, w_nstate;
    logic [WC_W-1:0]   r_wait_cnt, w_wait_nxt;
    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
    logic              w_front_en, w_back_en, w_ifid_fl, w_idex_fl, w_err, w_flush_inc;
    logic              w_load_use;
    logic [1:0]        w_fwd_a, w_fwd_b;

    assign w_load_use = ex_mem_read && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);

    always_comb begin
        w_front_en  = 1'b1;
        w_back_en   = 1'b1;
        w_ifid_fl   = 1'b0;
        w_idex_fl   = 1'b0;
        w_err       = 1'b0;
        w_flush_inc = 1'b0;
        w_nstate    = ST_RUN;
        w_wait_nxt  = '0;
        if (r_state == ST_MEM_WAIT && !dmem_ready) begin
            // Forced release: everything advances, no bubble, error pulse.
            if (MEM_TIMEOUT != 0 && r_wait_cnt == WC_MAX) begin
                w_err = 1'b1;
            end else begin
                w_front_en = 1'b0;
                w_back_en  = 1'b0;
                w_nstate   = ST_MEM_WAIT;
                w_wait_nxt = r_wait_cnt + WC_W'(1);
            end
        end else if (dmem_req && !dmem_ready) begin
            w_front_en = 1'b0;
            w_back_en  = 1'b0;
            w_nstate   = ST_MEM_WAIT;
            w_wait_nxt = WC_W'(1);
        end else if (ex_redirect) begin
            w_ifid_fl   = 1'b1;
            w_idex_fl   = 1'b1;
            w_flush_inc = 1'b1;
        end else if (w_load_use) begin
            w_front_en = 1'b0;
            w_idex_fl  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_nstate;
            r_wait_cnt <= w_wait_nxt;
            if (!w_front_en)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush_inc)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    forwarding_unit u_fwd (
        .i_ex_rs1        (ex_rs1),
        .i_ex_rs2        (ex_rs2),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_reg_write),
        .o_fwd_a         (w_fwd_a),
        .o_fwd_b         (w_fwd_b)
    );

    // Held in reset the pipeline registers are disabled and flushed.
    assign pc_en        = rst & w_front_en;
    assign ifid_en      = rst & w_front_en;
    assign idex_en      = rst & w_back_en;
    assign exmem_en     = rst & w_back_en;
    assign memwb_en     = rst & w_back_en;
    assign ifid_flush   = !rst | w_ifid_fl;
    assign idex_flush   = !rst | w_idex_fl;
    assign mem_err      = rst & w_err;
    assign fwd_a        = rst ? w_fwd_a : FWD_RF;
    assign fwd_b        = rst ? w_fwd_b : FWD_RF;
    assign stall_cycles = r_stall_cnt;
    assign flush_count  = r_flush_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage RV32I pipeline. It drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and produces EX-stage operand forwarding selects. It resolves load-use stalls, branch/jump redirects and multi-cycle data-memory waits, and it keeps stall and flush performance counters. It sits beside the pipeline registers in the top level and holds no datapath values.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 16: maximum frozen cycles per data-memory access; 0 disables the timeout.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `id_rs1`, `id_rs2` in 5: source registers of the instruction in ID.
- `ex_rs1`, `ex_rs2` in 5: source registers of the instruction in EX.
- `ex_rd` in 5, `ex_mem_read` in 1: destination register of the EX instruction and its load flag.
- `mem_rd` in 5, `mem_reg_write` in 1: destination register and write flag of the MEM instruction.
- `wb_rd` in 5, `wb_reg_write` in 1: destination register and write flag of the WB instruction.
- `ex_redirect` in 1: branch taken or jump resolved in EX.
- `dmem_req` in 1, `dmem_ready` in 1: MEM-stage access request and completion.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1: register enables.
- `ifid_flush`, `idex_flush` out 1: synchronous bubble insertion.
- `fwd_a`, `fwd_b` out 2: 00 = register file, 01 = WB result, 10 = MEM ALU result.
- `mem_err` out 1: one-cycle pulse on memory timeout.
- `stall_cycles`, `flush_count` out CNT_W: performance counters.

## Operation
- FSM states: RUN and MEM_WAIT. Reset state is RUN.
- **Priority in RUN** (also applies in MEM_WAIT on the cycle `dmem_ready` = 1):
  1. Memory wait.
  2. Redirect.
  3. Load-use stall.
  4. Normal advance.
- **Memory wait.** Condition: `dmem_req` && !`dmem_ready`.
  - All five enables = 0 and both flushes = 0.
  - Next state is MEM_WAIT and `wait_cnt` is set to 1.
- **Redirect.** Condition: `ex_redirect`.
  - All enables = 1; `ifid_flush` = `idex_flush` = 1.
  - `flush_count` increments by 1.
- **Load-use stall.** Condition: `ex_mem_read` && `ex_rd` != 0 && (`ex_rd` == `id_rs1` || `ex_rd` == `id_rs2`).
  - `pc_en` = `ifid_en` = 0.
  - `idex_flush` = 1; the remaining enables = 1.
  - Exactly one bubble is inserted; the consumer picks up the value through forwarding.
- **Normal advance.** All enables = 1 and both flushes = 0.
- **MEM_WAIT with `dmem_ready` = 0.**
  - If `MEM_TIMEOUT` != 0 and `wait_cnt` == `MEM_TIMEOUT`: `mem_err` = 1 and all enables = 1 (forced release); next state RUN.
  - Otherwise: everything is frozen and `wait_cnt` increments.
- **MEM_WAIT with `dmem_ready` = 1.** Apply the RUN rules for this cycle; next state RUN.
- **Redirect held during a freeze.** `ex_redirect` is ignored while the pipeline is frozen. The EX stage is also frozen, so the redirect is still asserted on the release cycle and is acted on then.
- **Forwarding, `fwd_a` shown (`fwd_b` identical with `ex_rs2`):**
  - 10 if `mem_reg_write` && `mem_rd` != 0 && `mem_rd` == `ex_rs1`;
  - else 01 if the same condition holds for WB;
  - else 00.
  - Purely combinational; MEM beats WB.
- **`stall_cycles`.** Increments on every cycle with `pc_en` = 0 while out of reset, including memory-wait freeze cycles.
- **Counter width.** Both counters wrap modulo 2^CNT_W.

## Timing
- Enables, flushes, forwarding selects and `mem_err` are combinational from the current state and inputs; they take effect at the next `clk` edge.
- State, `wait_cnt` and both counters are registered.
- **While `rst` = 0:**
  - all enables = 0; `ifid_flush` = `idex_flush` = 1;
  - `fwd_a` = `fwd_b` = 00; `mem_err` = 0;
  - both counters = 0; `wait_cnt` = 0; state RUN.
- **Reset during MEM_WAIT.** Returns to RUN immediately, with no `mem_err`.
- **Stall length.**
  - A memory wait with `dmem_ready` arriving N cycles after the request freezes the pipeline for exactly N cycles.
  - A timeout freezes for exactly `MEM_TIMEOUT` cycles; the release occurs on cycle `MEM_TIMEOUT` counted from the first freeze cycle (cycle 0).
- **Load-use latency.** Exactly one stall cycle.
- **`wait_cnt` width.** $clog2(MEM_TIMEOUT+1), minimum 1.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - FSM state encoding;
  - forwarding-select constants FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- Sub-module `forwarding_unit`: combinational; instantiated once and produces both `fwd_a` and `fwd_b`.
- The FSM, stall logic and counters live in the top module.

## Test plan
- **Load-use.** `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5 for one cycle -> `pc_en`=`ifid_en`=0 and `idex_flush`=1 for that cycle only; `stall_cycles`=1.
- **x0 exemption.** `ex_mem_read`=1, `ex_rd`=0, `id_rs2`=0 -> no stall. Also `mem_rd`=0 with `ex_rs1`=0 -> `fwd_a`=00.
- **Forward priority.** `mem_rd`=`wb_rd`=`ex_rs1`=7, both write flags 1 -> `fwd_a`=10. Then clear `mem_reg_write` -> `fwd_a`=01.
- **Memory wait.** `dmem_req`=1 with `dmem_ready` low for 3 cycles, then high -> all enables 0 for 3 cycles and 1 on the 4th; state back to RUN; `stall_cycles`=3.
- **Timeout.** `MEM_TIMEOUT`=4, `dmem_ready` never asserted -> freeze on cycles 0-3; on cycle 4, `mem_err`=1 for one cycle and all enables=1.
- **Simultaneous hazards and reset.**
  - `ex_redirect` + load-use condition together -> both flushes=1, `pc_en`=1, `flush_count`=1, `stall_cycles` unchanged.
  - `rst` asserted mid-MEM_WAIT -> counters 0, state RUN, flushes 1.
